// File: rtl/mmcm_drp_ctrl.sv
// MMCM dynamic reconfiguration controller: serialises DRP reads, masked
// read-modify-writes, and MMCM reset/lock sequencing behind a simple command port.
`timescale 1ns/1ps
module mmcm_drp_ctrl #(
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, RESP} state_t;

  localparam logic [1:0]  OP_RD     = 2'b00;
  localparam logic [1:0]  OP_RMW    = 2'b01;
  localparam logic [1:0]  OP_RST    = 2'b10;
  localparam logic [15:0] DRP_LAST  = 16'(DRP_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [15:0] data_reg;
  logic [15:0] mask_reg;
  logic [15:0] wait_cnt_reg;
  logic        lock_meta_reg;
  logic        lock_sync_reg;
  logic [15:0] merged;

  // Masked merge of the readback word with the command data, bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_merge
      assign merged[gi] = mask_reg[gi] ? data_reg[gi] : drp_do[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_ready     <= 1'b0;
      op_reg        <= 2'b00;
      data_reg      <= 16'h0000;
      mask_reg      <= 16'h0000;
      wait_cnt_reg  <= 16'h0000;
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
      drp_daddr     <= 7'h00;
      drp_di        <= 16'h0000;
      drp_den       <= 1'b0;
      drp_dwe       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 16'h0000;
      rsp_err       <= 1'b0;
      mmcm_rst      <= 1'b0;
    end else begin
      lock_meta_reg <= mmcm_locked;
      lock_sync_reg <= lock_meta_reg;
      // Strobes are single-cycle pulses; states that need them re-assert them.
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      rsp_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_reg    <= cmd_op;
            data_reg  <= cmd_data;
            mask_reg  <= cmd_mask;
            case (cmd_op)
              OP_RD, OP_RMW: begin
                state_reg <= RD;
                drp_den   <= 1'b1;
                drp_daddr <= cmd_addr;
              end
              OP_RST: begin
                mmcm_rst  <= 1'b1;
                state_reg <= RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= 16'h0000;
                rsp_err   <= 1'b0;
              end
              default: begin
                mmcm_rst     <= 1'b0;
                wait_cnt_reg <= 16'h0000;
                state_reg    <= LOCK_WAIT;
              end
            endcase
          end
        end

        RD: begin
          state_reg    <= RD_WAIT;
          wait_cnt_reg <= 16'h0000;
        end

        RD_WAIT: begin
          if (drp_drdy) begin
            if (op_reg == OP_RMW) begin
              state_reg <= WR;
              drp_den   <= 1'b1;
              drp_dwe   <= 1'b1;
              drp_di    <= merged;
            end else begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= drp_do;
              rsp_err   <= 1'b0;
            end
          end else if (wait_cnt_reg == DRP_LAST) begin
            // A failed readback never turns into a write.
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        WR: begin
          state_reg    <= WR_WAIT;
          wait_cnt_reg <= 16'h0000;
        end

        WR_WAIT: begin
          if (drp_drdy) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= drp_di;
            rsp_err   <= 1'b0;
          end else if (wait_cnt_reg == DRP_LAST) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        LOCK_WAIT: begin
          if (lock_sync_reg) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 16'h0001;
            rsp_err   <= 1'b0;
          end else if (wait_cnt_reg == LOCK_LAST) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        RESP: begin
          state_reg <= IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Bench for mmcm_drp_ctrl: expected responses are queued at issue time and a
// monitor checks them as rsp_valid pulses; a DRP slave model answers strobes.
`timescale 1ns/1ps
module tb_mmcm_drp_ctrl;
  localparam int DRP_TO  = 20;
  localparam int LOCK_TO = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_addr = 7'h00;
  logic [15:0] cmd_data = 16'h0000;
  logic [15:0] cmd_mask = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked = 1'b0;

  mmcm_drp_ctrl #(.DRP_TIMEOUT(DRP_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [15:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   rsp_count = 0;
  int   rsp_log[$];
  int   acc_log[$];
  int   acc_cyc = 0;

  // Monitor: one line per response, compared against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_count++;
      rsp_log.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: actual data=%h err=%b, required no response", rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_data !== mon_e.data || rsp_err !== mon_e.err) begin
          failures++;
          $display("FAIL rsp: actual data=%h err=%b, required data=%h err=%b",
                   rsp_data, rsp_err, mon_e.data, mon_e.err);
        end else begin
          $display("rsp ok: cycle=%0d data=%h err=%b", cyc, rsp_data, rsp_err);
        end
      end
    end
    if (rst_n && cmd_valid && cmd_ready) acc_log.push_back(cyc + 1);
  end

  // DRP slave model: answers each den with drdy drdy_delay cycles later.
  int          pend = 0;
  int          drdy_delay = 3;
  logic        rd_respond = 1'b1;
  logic        wr_respond = 1'b1;
  int          inject_req = 0;
  int          inject_ack = 0;
  logic [15:0] rd_value = 16'h0000;
  logic [15:0] last_di = 16'h0000;
  logic [6:0]  last_addr = 7'h00;
  int          den_count = 0;
  int          wr_count = 0;
  int          den_cyc = 0;
  int          drdy_cyc = 0;

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (!rst_n) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drp_drdy = 1'b1;
        drdy_cyc = cyc;
      end
    end
    if (inject_req != inject_ack) begin
      drp_drdy   = 1'b1;
      inject_ack = inject_req;
    end
    if (rst_n && drp_den) begin
      den_count++;
      den_cyc   = cyc;
      last_addr = drp_daddr;
      if (drp_dwe) begin
        wr_count++;
        last_di = drp_di;
        if (wr_respond) pend = drdy_delay;
      end else begin
        drp_do = rd_value;
        if (rd_respond) pend = drdy_delay;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [15:0] data,
                      input logic [15:0] mask, input logic push, input logic [15:0] ed,
                      input logic ee);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    if (push) exp_q.push_back({ed, ee});
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int t = 0;
    while (rsp_count < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, rsp_count, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int n, d0, w0, a0, r0, t;

  initial begin
    // Reset state and first cycle after release
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst_outputs", {28'b0, drp_den, drp_dwe, rsp_valid, mmcm_rst}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", {31'b0, cmd_ready}, 1);

    // Plain read, drdy three cycles after den
    n = rsp_count; d0 = den_count; w0 = wr_count;
    rd_value = 16'h1234;
    send(2'b00, 7'h08, 16'h0, 16'h0, 1'b1, 16'h1234, 1'b0);
    wait_rsp(n + 1, 50, "rd_done");
    chk("rd_den_pulses", den_count - d0, 1);
    chk("rd_no_write", wr_count - w0, 0);
    chk("rd_addr", {25'b0, last_addr}, 32'h08);
    chk("rd_den_cycle", den_cyc - acc_cyc, 0);
    chk("rd_latency", rsp_log[rsp_log.size() - 1] - drdy_cyc, 1);

    // Masked read-modify-write
    n = rsp_count; d0 = den_count; w0 = wr_count;
    rd_value = 16'hFF00;
    send(2'b01, 7'h09, 16'h00AB, 16'h00FF, 1'b1, 16'hFFAB, 1'b0);
    wait_rsp(n + 1, 50, "rmw_done");
    chk("rmw_den_pulses", den_count - d0, 2);
    chk("rmw_writes", wr_count - w0, 1);
    chk("rmw_di", {16'b0, last_di}, 32'hFFAB);
    chk("rmw_addr", {25'b0, last_addr}, 32'h09);

    // Read timeout, then a late drdy that must be ignored
    n = rsp_count; w0 = wr_count;
    rd_respond = 1'b0;
    send(2'b00, 7'h0A, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b1);
    wait_rsp(n + 1, DRP_TO + 20, "to_done");
    chk("to_cycles", rsp_log[rsp_log.size() - 1] - den_cyc, DRP_TO + 1);
    repeat (3) @(posedge clk);
    #1 inject_req++;
    repeat (10) @(negedge clk);
    chk("late_drdy_ignored", rsp_count, n + 1);
    chk("to_no_write", wr_count - w0, 0);
    chk("to_mmcm_rst", {31'b0, mmcm_rst}, 0);
    rd_respond = 1'b1;

    // MMCM reset, release, lock after 100 cycles
    n = rsp_count;
    send(2'b10, 7'h00, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    wait_rsp(n + 1, 20, "mrst_done");
    chk("mrst_asserted", {31'b0, mmcm_rst}, 1);
    send(2'b11, 7'h00, 16'h0, 16'h0, 1'b1, 16'h0001, 1'b0);
    chk("mrst_released", {31'b0, mmcm_rst}, 0);
    a0 = acc_cyc;
    repeat (100) @(negedge clk);
    mmcm_locked = 1'b1;
    wait_rsp(n + 2, 50, "lock_done");
    chk("lock_latency", rsp_log[rsp_log.size() - 1] - a0, 102);

    // Lock never arrives
    mmcm_locked = 1'b0;
    n = rsp_count;
    send(2'b10, 7'h00, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    wait_rsp(n + 1, 20, "mrst2_done");
    send(2'b11, 7'h00, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b1);
    a0 = acc_cyc;
    wait_rsp(n + 2, LOCK_TO + 20, "lock_to_done");
    chk("lock_to_cycles", rsp_log[rsp_log.size() - 1] - a0, LOCK_TO);

    // Reset during WR_WAIT aborts silently
    n = rsp_count;
    send(2'b10, 7'h00, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
    wait_rsp(n + 1, 20, "mrst3_done");
    n = rsp_count; w0 = wr_count;
    wr_respond = 1'b0;
    rd_value = 16'h0F0F;
    send(2'b01, 7'h0B, 16'h1111, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    t = 0;
    while (wr_count == w0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("abort_wr_issued", wr_count - w0, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_outputs", {27'b0, drp_den, drp_dwe, rsp_valid, mmcm_rst, cmd_ready}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_ready", {31'b0, cmd_ready}, 1);
    chk("abort_no_rsp", rsp_count, n);
    wr_respond = 1'b1;
    rd_value = 16'h5A5A;
    send(2'b00, 7'h0C, 16'h0, 16'h0, 1'b1, 16'h5A5A, 1'b0);
    wait_rsp(n + 1, 50, "post_abort_rd");

    // Back-to-back with cmd_valid held high
    n = rsp_count; a0 = acc_log.size(); r0 = rsp_log.size();
    rd_value = 16'h0042;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 7'h10;
    exp_q.push_back({16'h0042, 1'b0});
    exp_q.push_back({16'h0042, 1'b0});
    t = 0;
    while (acc_log.size() < a0 + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_rsp(n + 2, 100, "b2b_done");
    chk("b2b_accepts", acc_log.size() - a0, 2);
    chk("b2b_second_accept", acc_log[a0 + 1] - rsp_log[r0], 2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 SHALL have parameter DRP_TIMEOUT, default 64: max cycles waiting for drp_drdy before error.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: max cycles waiting for lock after reset release.
REQ-003 SHALL have one clock and a synchronous, active-low reset; all ports listed below.
REQ-004 clk  in  1  sole clock; also drives the MMCM DRP DCLK.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  controller idle, command accepted when both high at clk edge.
REQ-008 cmd_op  in  2  00 read, 01 masked write (RMW), 10 assert MMCM reset, 11 release MMCM reset and wait lock.
REQ-009 cmd_addr  in  7  DRP register address.
REQ-010 cmd_data  in  16  write data.
REQ-011 cmd_mask  in  16  1 = bit taken from cmd_data, 0 = bit kept from readback.
REQ-012 rsp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-013 rsp_data  out  16  read value, written value, or {15'b0,lock}.
REQ-014 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-015 drp_daddr / drp_di  out  7 / 16  DRP address / write data.
REQ-016 drp_den / drp_dwe  out  1 / 1  DRP enable / write enable.
REQ-017 drp_do / drp_drdy  in  16 / 1  DRP read data / ready.
REQ-018 mmcm_rst  out  1  MMCM reset request.
REQ-019 mmcm_locked  in  1  MMCM LOCKED, asynchronous.

Function
REQ-020 SHALL implement states IDLE, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, RESP.
REQ-021 SHALL drive cmd_ready high only in IDLE; acceptance captures op/addr/data/mask.
REQ-022 Read (00): RD in cycle after acceptance, drp_den=1, drp_dwe=0, drp_daddr=addr for exactly one cycle; then RD_WAIT.
REQ-023 RD_WAIT on drp_drdy=1: capture drp_do; op 00 -> RESP with rsp_data=drp_do, rsp_err=0.
REQ-024 RMW (01): after readback capture, WR next cycle: drp_den=drp_dwe=1 one cycle, drp_di=(rdata & ~mask)|(data & mask); then WR_WAIT.
REQ-025 WR_WAIT on drp_drdy=1 -> RESP, rsp_data=written value, rsp_err=0.
REQ-026 drp_drdy SHALL be sampled only in RD_WAIT/WR_WAIT; drdy in any other state ignored (late ack after timeout harmless).
REQ-027 16-bit wait counter cleared on entering each WAIT state, +1 per cycle; reaching DRP_TIMEOUT without drdy -> RESP, rsp_err=1, rsp_data=0, no write issued.
REQ-028 Op 10: mmcm_rst<=1, go to RESP; rsp_data=0, rsp_err=0.
REQ-029 Op 11: mmcm_rst<=0, go to LOCK_WAIT; mmcm_locked passed through 2-flop synchronizer; sync lock=1 -> RESP, rsp_data=1, err=0; LOCK_TIMEOUT cycles -> RESP, rsp_data=0, err=1.
REQ-030 RESP: rsp_valid=1 exactly one cycle, then IDLE; cmd_ready high the following cycle.
REQ-031 drp_den, drp_dwe, rsp_valid SHALL be zero outside the states defined above; drp_daddr/drp_di hold last value.
REQ-032 mmcm_rst SHALL change only on ops 10/11 and reset; unaffected by DRP timeouts.
REQ-033 Read latency: rsp_valid = drdy cycle + 1; drdy earliest one cycle after den.

Reset
REQ-034 rst_n=0 at clk edge SHALL force IDLE, all outputs 0 (cmd_ready=0 during reset, 1 first cycle after), counters and sync flops 0.
REQ-035 Reset mid-transaction SHALL abort without rsp_valid; DRP strobes drop next cycle; mmcm_rst returns 0.

Verification
REQ-036 Read addr 0x08, DRP model drdy 3 cycles after den with do=0x1234 -> one den pulse, dwe=0, rsp_data=0x1234, err=0.
REQ-037 RMW addr 0x09, readback 0xFF00, data 0x00AB, mask 0x00FF -> read then write di=0xFFAB, rsp_data=0xFFAB.
REQ-038 Read with drdy never returned -> rsp_valid exactly DRP_TIMEOUT cycles into RD_WAIT, err=1, data=0; drdy injected later ignored, no extra rsp.
REQ-039 Op 10 then op 11, lock rises 100 cycles after release -> mmcm_rst 1 then 0, rsp_data=1, err=0; repeat with lock held low -> err=1 after LOCK_TIMEOUT.
REQ-040 Reset asserted in WR_WAIT -> no rsp_valid, den/dwe low, cmd_ready=1 first cycle after release; next read completes normally.
REQ-041 Back-to-back cmd_valid held high -> second command accepted only cycle after first rsp_valid.
